// File: rtl/rv32_e_div_ctrl.sv
// RV32M divide unit for the execute stage: 32-step radix-2 restoring division
// with a front-end stall until the quotient or remainder is ready.
module rv32_e_div_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        stall_m_i,
  input  logic        valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        stall_e_o,
  output logic        busy_o,
  output logic        result_valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [4:0]  count;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] div;
  logic [1:0]  op;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;

  logic        start;
  logic        abort;
  logic        is_signed;
  logic        dividend_neg;
  logic        divisor_neg;
  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic        div_zero;
  logic        overflow;
  logic        special;
  logic [31:0] special_result;

  logic [32:0] rem_shift;
  logic [32:0] trial;
  logic        trial_ok;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] calc_result;

  // Operand conditioning; |0x80000000| stays 0x80000000, read as unsigned.
  always_comb begin
    start          = (state == IDLE) && valid_i && !flush_i;
    abort          = flush_i || !valid_i;
    is_signed      = !op_i[0];
    dividend_neg   = is_signed && dividend_i[31];
    divisor_neg    = is_signed && divisor_i[31];
    dividend_abs   = dividend_neg ? (32'd0 - dividend_i) : dividend_i;
    divisor_abs    = divisor_neg ? (32'd0 - divisor_i) : divisor_i;
    div_zero       = (divisor_i == 32'd0);
    overflow       = is_signed && (dividend_i == 32'h8000_0000) &&
                     (divisor_i == 32'hFFFF_FFFF);
    special        = div_zero || overflow;
    if (div_zero) begin
      special_result = op_i[1] ? dividend_i : 32'hFFFF_FFFF;
    end else begin
      special_result = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step plus the sign fix applied on the final step.
  always_comb begin
    rem_shift   = {rem, quo[31]};
    trial       = rem_shift - {1'b0, div};
    trial_ok    = !trial[32];
    rem_step    = trial_ok ? trial[31:0] : rem_shift[31:0];
    quo_step    = {quo[30:0], trial_ok};
    quo_fixed   = (neg_a ^ neg_b) ? (32'd0 - quo_step) : quo_step;
    rem_fixed   = neg_a ? (32'd0 - rem_step) : rem_step;
    calc_result = op[1] ? rem_fixed : quo_fixed;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Flush or a dropped valid_i aborts any operation, taking priority over start.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (abort) begin
          next_state = IDLE;
        end else if (count == 5'd0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (abort || !stall_m_i) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count        <= 5'd0;
      rem          <= 32'd0;
      quo          <= 32'd0;
      div          <= 32'd0;
      op           <= 2'd0;
      neg_a        <= 1'b0;
      neg_b        <= 1'b0;
      result       <= 32'd0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      result_valid <= (next_state == DONE);
      busy         <= (next_state != IDLE);
      if (start) begin
        op    <= op_i;
        neg_a <= dividend_neg;
        neg_b <= divisor_neg;
        rem   <= 32'd0;
        quo   <= dividend_abs;
        div   <= divisor_abs;
        count <= 5'd31;
        if (special) begin
          result <= special_result;
        end
      end else if ((state == CALC) && !abort) begin
        rem <= rem_step;
        quo <= quo_step;
        if (count == 5'd0) begin
          result <= calc_result;
        end else begin
          count <= count - 5'd1;
        end
      end
    end
  end

  always_comb begin
    stall_e_o      = valid_i && !flush_i && (state != DONE);
    busy_o         = busy;
    result_valid_o = result_valid;
    result_o       = result_valid ? result : 32'd0;
  end

endmodule

// File: tb/tb_rv32_e_div_ctrl.sv
// Self-checking bench for rv32_e_div_ctrl: expected results queued at issue
// and compared when result_valid_o appears.
module tb_rv32_e_div_ctrl;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk_i;
  logic        rst_n_i;
  logic        flush_i;
  logic        stall_m_i;
  logic        valid_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        stall_e_o;
  logic        busy_o;
  logic        result_valid_o;
  logic [31:0] result_o;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  rv32_e_div_ctrl dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .flush_i        (flush_i),
    .stall_m_i      (stall_m_i),
    .valid_i        (valid_i),
    .op_i           (op_i),
    .dividend_i     (dividend_i),
    .divisor_i      (divisor_i),
    .stall_e_o      (stall_e_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model built on the language's own division operators.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      OP_DIV:  return sa / sb;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Issues one divide at a negedge and waits (bounded) for result_valid_o.
  task automatic do_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic [31:0] res, output bit timed_out);
    @(negedge clk_i);
    valid_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    stalls     = 0;
    res        = 32'd0;
    timed_out  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (result_valid_o) begin
        res       = result_o;
        timed_out = 1'b0;
        break;
      end
      if (stall_e_o) stalls++;
      @(negedge clk_i);
    end
  endtask

  task automatic go_idle();
    @(negedge clk_i);
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if ({busy_o, result_valid_o, stall_e_o} !== 3'b000 || result_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got busy=%b valid=%b stall=%b result=%h want 0 0 0 0",
               busy_o, result_valid_o, stall_e_o, result_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Each entry: op, dividend, divisor, expected result, expected stall cycles.
  task automatic test_table();
    logic [1:0]  t_op [11];
    logic [31:0] t_a  [11];
    logic [31:0] t_b  [11];
    logic [31:0] t_r  [11];
    int          t_s  [11];
    int          st;
    logic [31:0] res;
    logic [31:0] want;
    bit          to;
    t_op[0]  = OP_DIVU; t_a[0]  = 32'd100;        t_b[0]  = 32'd7;          t_r[0]  = 32'd14;         t_s[0]  = 33;
    t_op[1]  = OP_REMU; t_a[1]  = 32'd100;        t_b[1]  = 32'd7;          t_r[1]  = 32'd2;          t_s[1]  = 33;
    t_op[2]  = OP_DIV;  t_a[2]  = 32'hFFFF_FFF9;  t_b[2]  = 32'd2;          t_r[2]  = 32'hFFFF_FFFD;  t_s[2]  = 33;
    t_op[3]  = OP_REM;  t_a[3]  = 32'hFFFF_FFF9;  t_b[3]  = 32'd2;          t_r[3]  = 32'hFFFF_FFFF;  t_s[3]  = 33;
    t_op[4]  = OP_DIV;  t_a[4]  = 32'd7;          t_b[4]  = 32'hFFFF_FFFE;  t_r[4]  = 32'hFFFF_FFFD;  t_s[4]  = 33;
    t_op[5]  = OP_DIV;  t_a[5]  = 32'd5;          t_b[5]  = 32'd0;          t_r[5]  = 32'hFFFF_FFFF;  t_s[5]  = 1;
    t_op[6]  = OP_REM;  t_a[6]  = 32'd5;          t_b[6]  = 32'd0;          t_r[6]  = 32'd5;          t_s[6]  = 1;
    t_op[7]  = OP_DIV;  t_a[7]  = 32'h8000_0000;  t_b[7]  = 32'hFFFF_FFFF;  t_r[7]  = 32'h8000_0000;  t_s[7]  = 1;
    t_op[8]  = OP_REM;  t_a[8]  = 32'h8000_0000;  t_b[8]  = 32'hFFFF_FFFF;  t_r[8]  = 32'd0;          t_s[8]  = 1;
    t_op[9]  = OP_DIVU; t_a[9]  = 32'h8000_0000;  t_b[9]  = 32'hFFFF_FFFF;  t_r[9]  = 32'd0;          t_s[9]  = 33;
    t_op[10] = OP_REM;  t_a[10] = 32'd7;          t_b[10] = 32'hFFFF_FFFE;  t_r[10] = 32'd1;          t_s[10] = 33;
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(t_r[i]);
      do_div(t_op[i], t_a[i], t_b[i], st, res, to);
      want = exp_q.pop_front();
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL table%0d_timeout got no result_valid_o want result within 64 cycles", i);
      end
      checks++;
      if (res !== want) begin
        errors++;
        $display("[TB] FAIL table%0d_result got %h want %h", i, res, want);
      end
      checks++;
      if (st !== t_s[i]) begin
        errors++;
        $display("[TB] FAIL table%0d_stall_cycles got %0d want %0d", i, st, t_s[i]);
      end
      go_idle();
    end
  endtask

  task automatic test_flush();
    int          st;
    logic [31:0] res;
    logic [31:0] want;
    bit          to;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (10) @(negedge clk_i);
    flush_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b1 || stall_e_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_in_calc got busy=%b stall=%b want 1 0", busy_o, stall_e_o);
    end
    @(negedge clk_i);
    flush_i = 1'b0;
    valid_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, stall_e_o, result_valid_o} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL flush_after got busy=%b stall=%b valid=%b want 0 0 0",
               busy_o, stall_e_o, result_valid_o);
    end
    exp_q.push_back(32'd3);
    do_div(OP_DIVU, 32'd9, 32'd3, st, res, to);
    want = exp_q.pop_front();
    checks++;
    if (to || res !== want || st !== 33) begin
      errors++;
      $display("[TB] FAIL flush_then_divu got res=%h stalls=%0d timeout=%0d want %h 33 0",
               res, st, to, want);
    end
    go_idle();
  endtask

  task automatic test_stall_m();
    int          st;
    logic [31:0] res;
    logic [31:0] want;
    bit          to;
    stall_m_i = 1'b1;
    exp_q.push_back(32'd33);
    do_div(OP_DIVU, 32'd99, 32'd3, st, res, to);
    want = exp_q.pop_front();
    checks++;
    if (to || res !== want) begin
      errors++;
      $display("[TB] FAIL stall_m_first got res=%h timeout=%0d want %h 0", res, to, want);
    end
    for (int k = 1; k < 5; k++) begin
      @(negedge clk_i);
      if (k == 4) stall_m_i = 1'b0;
      #1;
      checks++;
      if (result_valid_o !== 1'b1 || result_o !== want || stall_e_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_m_hold%0d got valid=%b res=%h stall=%b want 1 %h 0",
                 k, result_valid_o, result_o, stall_e_o, want);
      end
    end
    go_idle();
    #1;
    checks++;
    if (result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_m_release got valid=%b busy=%b want 0 0", result_valid_o, busy_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    valid_i = 1'b1; op_i = OP_DIV; dividend_i = 32'd12345; divisor_i = 32'd17;
    repeat (5) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, result_valid_o, stall_e_o} !== 3'b000 || result_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got busy=%b valid=%b stall=%b result=%h want 0 0 0 0",
               busy_o, result_valid_o, stall_e_o, result_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    int          st;
    int          want_st;
    logic [31:0] res;
    logic [31:0] want;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    bit          to;
    for (int i = 0; i < 6; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      want_st = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      exp_q.push_back(model(op, a, b));
      do_div(op, a, b, st, res, to);
      want = exp_q.pop_front();
      checks++;
      if (to || res !== want || st !== want_st) begin
        errors++;
        $display("[TB] FAIL b2b%0d op=%0d a=%h b=%h got res=%h stalls=%0d timeout=%0d want %h %0d 0",
                 i, op, a, b, res, st, to, want, want_st);
      end
    end
    go_idle();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    flush_i    = 1'b0;
    stall_m_i  = 1'b0;
    valid_i    = 1'b0;
    op_i       = 2'd0;
    dividend_i = 32'd0;
    divisor_i  = 32'd0;
    test_reset();
    test_table();
    test_flush();
    test_stall_m();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_e_div_ctrl.md
# rv32_e_div_ctrl

Multi-cycle controller and iterative datapath for the RV32M divide group (DIV, DIVU, REM, REMU) in the execute stage. It accepts operands already forwarded and muxed by the execute stage. It runs a 32-step radix-2 restoring division and holds the front of the pipeline (fetch, decode, execute) with a stall until the result is ready. The result is then muxed into the ALU result path, so it enters the execute-to-memory register like any single-cycle ALU result.

## Interface
- No parameters; datapath width fixed at 32.
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- flush_i  in  1  kill the in-flight operation (branch/jump redirect or exception).
- stall_m_i  in  1  memory-stage stall; the execute-to-memory register does not load this cycle.
- valid_i  in  1  execute stage holds a divide instruction; level, held until the instruction leaves execute.
- op_i  in  2  instruction funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend_i  in  32  rs1 after forwarding.
- divisor_i  in  32  rs2 after forwarding.
- stall_e_o  out  1  freeze fetch, decode and execute; bubble not inserted.
- busy_o  out  1  state is not IDLE.
- result_valid_o  out  1  result_o holds the final value.
- result_o  out  32  quotient or remainder; 0 when result_valid_o=0.

## Operation
- States: IDLE, CALC, DONE.
- Reset: state IDLE, step counter 0, remainder/quotient registers 0, result_o 0, result_valid_o 0, busy_o 0, stall_e_o 0.
- stall_e_o = valid_i & ~flush_i & (state != DONE). Purely combinational from the registered state.
- IDLE, valid_i=1, flush_i=0:
  - latch op_i and the operand signs.
  - signed ops (DIV, REM): latch |dividend_i| and |divisor_i|; unsigned ops: latch raw values. |0x80000000| = 0x80000000 as unsigned.
  - if the case is special (see below), register the special result and go to DONE.
  - otherwise clear the partial remainder, load counter 31, and go to CALC.
- CALC, each cycle:
  - shift {rem, quo} left by 1.
  - trial = rem_shifted − divisor, computed 33 bits wide.
  - if the trial is non-negative, rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - when counter = 0, apply the sign fix, register the result and go to DONE; otherwise decrement the counter.
- Sign fix:
  - DIV: negate the quotient if the dividend and divisor signs differ.
  - REM: the remainder takes the dividend's sign (negate if dividend < 0).
  - DIVU, REMU: no correction.
- Special cases, resolved in IDLE with no CALC:
  - divisor = 0: quotient 0xFFFFFFFF, remainder = dividend_i.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- DONE: result_valid_o=1 and result_o = quotient (op_i[1]=0) or remainder (op_i[1]=1). Go to IDLE when stall_m_i=0; stay in DONE while stall_m_i=1.
- flush_i=1 in any state: next state IDLE and result_valid_o 0; the flush takes priority over a start in the same cycle.
- Operand or op_i changes after IDLE are ignored; latched values are used.
- valid_i dropping without flush_i: abort to IDLE, same as a flush.

## Timing
- Normal op: valid_i rises in cycle 0 (IDLE, load).
  - cycles 1–32: CALC.
  - cycle 33: DONE, result_valid_o=1.
  - stall_e_o is high for cycles 0–32 (33 cycles) and low in cycle 33.
  - with stall_m_i=0, the result is captured into the execute-to-memory register at the end of cycle 33.
- Special case: cycle 0 IDLE, cycle 1 DONE; 1 stall cycle.
- Back-to-back divides: the second valid_i is seen in IDLE in the cycle after DONE; no overlap.
- Asynchronous reset mid-CALC: all outputs return to their reset values immediately.
- busy_o and result_valid_o are registered; stall_e_o is combinational.

## Test plan
- DIVU 100 / 7: stall_e_o high for 33 cycles, then result_valid_o=1, result_o=14; REMU 100 % 7 gives 2.
- DIV −7 / 2 gives 0xFFFFFFFD (−3); REM −7 % 2 gives 0xFFFFFFFF (−1); DIV 7 / −2 gives −3.
- Divide by zero: DIV 5 / 0 gives 0xFFFFFFFF after 1 stall cycle; REM 5 % 0 gives 5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 after 1 stall cycle; REM gives 0; DIVU of the same operands runs the full 33 cycles and gives 0.
- flush_i asserted in CALC cycle 10: next cycle state IDLE, stall_e_o=0, result_valid_o=0; a new DIVU 9 / 3 then completes with 3 after 33 stall cycles.
- stall_m_i held high for 4 cycles at DONE: result_o stays valid and constant for 5 cycles, stall_e_o=0, then IDLE.
